// File: rtl/mem_if_ctrl_pkg.sv
// Shared definitions for the mem_if_ctrl memory interface.
//   state_t       : controller FSM states (IDLE=0, WAIT=1, RESP=2)
//   DEF_DATA_W    : default data word width (19-bit datapath)
//   DEF_ADDR_W    : default word-address width
//   CNT_W         : wait-state counter width (covers WAIT_CYCLES 0..15)
//   PAR_W         : extra stored bits per word for parity (1 when
//                   MEM_IF_PARITY_EN is defined, else 0)
//   idx_width()   : array index width for a given DEPTH (minimum 1)
package mem_if_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned DEF_DATA_W = 19;
  localparam int unsigned DEF_ADDR_W = 19;
  localparam int unsigned CNT_W      = 4;

`ifdef MEM_IF_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_if_array.sv
// Storage array for mem_if_ctrl: synchronous write, registered read.
// Contents are not reset.
//   clk   : rising-edge clock
//   we    : write enable, commits wdata to mem[idx]
//   re    : read enable, captures mem[idx] into rdata
//   idx   : word index
//   wdata : write word (WIDTH bits)
//   rdata : registered read word, holds until the next read
module mem_if_array #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [IDX_W-1:0] idx,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/mem_if_ctrl.sv
// CPU load/store memory interface controller.
// valid/ready request handshake, WAIT_CYCLES extra wait states, one-cycle
// response pulse and out-of-range address detection in front of on-chip RAM.
// Optional macro MEM_IF_PARITY_EN stores an even-parity bit per word and
// flags mismatches on read via rsp_perr (otherwise rsp_perr is tied to 0).
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_valid   : request present
//   req_ready   : request accepted this cycle (high only in IDLE)
//   req_write   : 1 = write, 0 = read (sampled on accept)
//   req_addr    : word address (sampled on accept)
//   req_wdata   : write data (sampled on accept)
//   rsp_valid   : one-cycle response pulse
//   rsp_rdata   : read data, 0 for writes and errors
//   rsp_err     : address >= DEPTH
//   rsp_perr    : parity mismatch on read
//   busy        : controller not idle
module mem_if_ctrl
  import mem_if_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_perr,
  output logic              busy
);

  localparam int unsigned MEM_W = DATA_W + PAR_W;
  localparam int unsigned IDX_W = idx_width(DEPTH);

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt, cnt_next;

  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              accept, enter_resp, in_range;
  logic              arr_we, arr_re;
  logic [MEM_W-1:0]  arr_wdata, arr_rdata;

  logic              err_q;
  logic              rd_ok_q;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          cnt_next   = CNT_W'(WAIT_CYCLES);
          next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) next_state = RESP;
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // With WAIT_CYCLES==0 the RESP entry edge is the accept edge itself, when
  // the command register is not yet loaded, so the access takes the request
  // fields directly while in IDLE.
  assign acc_write  = (state == IDLE) ? req_write : cmd_write;
  assign acc_addr   = (state == IDLE) ? req_addr  : cmd_addr;
  assign acc_wdata  = (state == IDLE) ? req_wdata : cmd_wdata;
  assign enter_resp = (next_state == RESP) && (state != RESP);

  // Full-width compare: upper address bits never alias into the array.
  assign in_range = ({1'b0, acc_addr} < (ADDR_W + 1)'(DEPTH));
  assign arr_we   = enter_resp && acc_write && in_range;
  assign arr_re   = enter_resp && !acc_write && in_range;

`ifdef MEM_IF_PARITY_EN
  assign arr_wdata = {^acc_wdata, acc_wdata};
  assign rsp_perr  = rd_ok_q && (^arr_rdata);
`else
  assign arr_wdata = acc_wdata;
  assign rsp_perr  = 1'b0;
`endif

  // Array read data is held until the next read; masking with rd_ok_q
  // gives 0 after writes, errors and reset.
  assign rsp_rdata = rd_ok_q ? arr_rdata[DATA_W-1:0] : '0;
  assign rsp_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      err_q     <= 1'b0;
      rd_ok_q   <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      if (accept) begin
        cmd_write <= req_write;
        cmd_addr  <= req_addr;
        cmd_wdata <= req_wdata;
      end
      if (enter_resp) begin
        err_q   <= !in_range;
        rd_ok_q <= arr_re;
      end
    end
  end

  mem_if_array #(
    .WIDTH (MEM_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (acc_addr[IDX_W-1:0]),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

endmodule
